// File: rtl/ex_mac_unit.sv
// Iterative radix-2^R multiply / multiply-accumulate unit covering MUL/MLA and the
// long-multiply forms, with valid/ready handshakes on both sides.
module ex_mac_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned R       = 2,
    parameter int unsigned LONG_EN = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic            i_flush,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [XLEN-1:0] i_acc_lo,
    input  logic [XLEN-1:0] i_acc_hi,
    input  logic            i_s,
    input  logic [3:0]      i_nzcv,
    input  logic [3:0]      i_rd_lo_code,
    input  logic [3:0]      i_rd_hi_code,
    output logic            o_vld,
    input  logic            i_rdy,
    output logic [XLEN-1:0] o_res_lo,
    output logic [XLEN-1:0] o_res_hi,
    output logic            o_rd_lo_en,
    output logic            o_rd_hi_en,
    output logic [3:0]      o_rd_lo_code,
    output logic [3:0]      o_rd_hi_code,
    output logic            o_nzcv_en,
    output logic [3:0]      o_nzcv
);

    localparam int unsigned Iters = XLEN / R;
    localparam int unsigned CntW  = $clog2(Iters + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StFin, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mult_q, mult_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                neg_q, neg_d;
    logic                long_q, long_d;
    logic                acc_q, acc_d;
    logic                s_q, s_d;
    logic [1:0]          cv_q, cv_d;
    logic [XLEN-1:0]     acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]     acc_hi_q, acc_hi_d;
    logic [3:0]          lo_code_q, lo_code_d;
    logic [3:0]          hi_code_q, hi_code_d;

    logic                op_long, op1_neg, op2_neg;
    logic [XLEN-1:0]     op1_mag, op2_mag;
    logic [2*XLEN-1:0]   partial, p_signed, acc_ext, p_fin;
    logic                done, res_n, res_z;

    // N and Z come from the result; only C and V are carried through.
    logic unused_nz;
    assign unused_nz = ^i_nzcv[3:2];

    always_comb begin
        op_long = i_op[2] & (LONG_EN != 0);
        op1_neg = i_op[1] & i_op1[XLEN-1];
        op2_neg = i_op[1] & i_op2[XLEN-1];
        op1_mag = op1_neg ? -i_op1 : i_op1;
        op2_mag = op2_neg ? -i_op2 : i_op2;

        partial  = mcand_q * (2*XLEN)'(mult_q[R-1:0]);
        p_signed = neg_q ? -prod_q : prod_q;
        acc_ext  = long_q ? {acc_hi_q, acc_lo_q} : {{XLEN{1'b0}}, acc_lo_q};
        p_fin    = acc_q ? p_signed + acc_ext : p_signed;
        if (!long_q) begin
            p_fin[2*XLEN-1:XLEN] = '0;
        end

        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        long_d    = long_q;
        acc_d     = acc_q;
        s_d       = s_q;
        cv_d      = cv_q;
        acc_lo_d  = acc_lo_q;
        acc_hi_d  = acc_hi_q;
        lo_code_d = lo_code_q;
        hi_code_d = hi_code_q;

        unique case (state_q)
            StIdle: begin
                if (i_vld && !i_flush) begin
                    state_d   = StBusy;
                    count_d   = CntW'(Iters);
                    mcand_d   = {{XLEN{1'b0}}, op1_mag};
                    mult_d    = op2_mag;
                    prod_d    = '0;
                    neg_d     = op1_neg ^ op2_neg;
                    long_d    = op_long;
                    acc_d     = i_op[0];
                    s_d       = i_s;
                    cv_d      = i_nzcv[1:0];
                    acc_lo_d  = i_acc_lo;
                    acc_hi_d  = i_acc_hi;
                    lo_code_d = i_rd_lo_code;
                    hi_code_d = i_rd_hi_code;
                end
            end
            StBusy: begin
                if (i_flush) begin
                    state_d = StIdle;
                end else begin
                    prod_d  = prod_q + partial;
                    mcand_d = mcand_q << R;
                    mult_d  = mult_q >> R;
                    count_d = count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                if (i_flush) begin
                    state_d = StIdle;
                end else begin
                    prod_d  = p_fin;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_flush || i_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            long_q    <= 1'b0;
            acc_q     <= 1'b0;
            s_q       <= 1'b0;
            cv_q      <= '0;
            acc_lo_q  <= '0;
            acc_hi_q  <= '0;
            lo_code_q <= '0;
            hi_code_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
            long_q    <= long_d;
            acc_q     <= acc_d;
            s_q       <= s_d;
            cv_q      <= cv_d;
            acc_lo_q  <= acc_lo_d;
            acc_hi_q  <= acc_hi_d;
            lo_code_q <= lo_code_d;
            hi_code_q <= hi_code_d;
        end
    end

    // Every result-side output is gated by DONE so nothing leaks out mid-operation.
    always_comb begin
        done  = (state_q == StDone);
        res_n = long_q ? prod_q[2*XLEN-1] : prod_q[XLEN-1];
        res_z = long_q ? (prod_q == '0) : (prod_q[XLEN-1:0] == '0);

        o_rdy        = (state_q == StIdle);
        o_vld        = done;
        o_res_lo     = done ? prod_q[XLEN-1:0] : '0;
        o_res_hi     = (done && long_q) ? prod_q[2*XLEN-1:XLEN] : '0;
        o_rd_hi_en   = done & long_q;
        o_rd_lo_en   = done & ~(long_q & (lo_code_q == hi_code_q));
        o_rd_lo_code = done ? lo_code_q : '0;
        o_rd_hi_code = done ? hi_code_q : '0;
        o_nzcv_en    = done & s_q;
        o_nzcv       = done ? {res_n, res_z, cv_q} : '0;
    end

endmodule

// File: tb/tb_ex_mac_unit.sv
// Scoreboard bench for ex_mac_unit: three instances (R = 1, 2, 4) share stimulus,
// one is selected at a time; expected results come from a 64-bit reference model.
module tb_ex_mac_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, vld, flush, s, rdy;
    logic [2:0]  op;
    logic [31:0] op1, op2, acc_lo, acc_hi;
    logic [3:0]  nzcv_in, lo_code, hi_code;
    int          sel;

    logic        rdy_a[3], vld_o_a[3], lo_en_a[3], hi_en_a[3], nzcv_en_a[3], vld_i_a[3];
    logic [31:0] res_lo_a[3], res_hi_a[3];
    logic [3:0]  lo_code_a[3], hi_code_a[3], nzcv_a[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned RV = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        assign vld_i_a[g] = vld && (sel == g);
        ex_mac_unit #(.XLEN(XLEN), .R(RV), .LONG_EN(1)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_vld        (vld_i_a[g]),
            .o_rdy        (rdy_a[g]),
            .i_flush      (flush),
            .i_op         (op),
            .i_op1        (op1),
            .i_op2        (op2),
            .i_acc_lo     (acc_lo),
            .i_acc_hi     (acc_hi),
            .i_s          (s),
            .i_nzcv       (nzcv_in),
            .i_rd_lo_code (lo_code),
            .i_rd_hi_code (hi_code),
            .o_vld        (vld_o_a[g]),
            .i_rdy        (rdy),
            .o_res_lo     (res_lo_a[g]),
            .o_res_hi     (res_hi_a[g]),
            .o_rd_lo_en   (lo_en_a[g]),
            .o_rd_hi_en   (hi_en_a[g]),
            .o_rd_lo_code (lo_code_a[g]),
            .o_rd_hi_code (hi_code_a[g]),
            .o_nzcv_en    (nzcv_en_a[g]),
            .o_nzcv       (nzcv_a[g])
        );
    end

    wire        m_rdy     = rdy_a[sel];
    wire        m_vld     = vld_o_a[sel];
    wire [31:0] m_lo      = res_lo_a[sel];
    wire [31:0] m_hi      = res_hi_a[sel];
    wire        m_lo_en   = lo_en_a[sel];
    wire        m_hi_en   = hi_en_a[sel];
    wire [3:0]  m_lo_code = lo_code_a[sel];
    wire [3:0]  m_hi_code = hi_code_a[sel];
    wire        m_nzcv_en = nzcv_en_a[sel];
    wire [3:0]  m_nzcv    = nzcv_a[sel];

    typedef struct {
        logic [31:0] lo, hi;
        logic        lo_en, hi_en, nzcv_en;
        logic [3:0]  lo_code, hi_code, nzcv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] al, input logic [31:0] ah, input logic sf,
                                   input logic [3:0] nz, input logic [3:0] lc, input logic [3:0] hc);
        exp_t        e;
        logic [63:0] x, y, p;
        x = o[1] ? {{32{a[31]}}, a} : {32'b0, a};
        y = o[1] ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        if (o[0]) p = p + (o[2] ? {ah, al} : {32'b0, al});
        e.lo      = p[31:0];
        e.lo_code = lc;
        e.hi_code = hc;
        e.nzcv_en = sf;
        if (o[2]) begin
            e.hi    = p[63:32];
            e.hi_en = 1'b1;
            e.lo_en = (lc != hc);
            e.nzcv  = {p[63], p == 64'd0, nz[1:0]};
        end else begin
            e.hi    = 32'd0;
            e.hi_en = 1'b0;
            e.lo_en = 1'b1;
            e.nzcv  = {p[31], p[31:0] == 32'd0, nz[1:0]};
        end
        return e;
    endfunction

    // Returns on the falling edge just after the accepting rising edge.
    task automatic issue(input int inst, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] al, input logic [31:0] ah,
                         input logic sf, input logic [3:0] nz, input logic [3:0] lc,
                         input logic [3:0] hc, input bit push);
        int waited = 0;
        sel = inst;
        @(negedge clk);
        op = o; op1 = a; op2 = b; acc_lo = al; acc_hi = ah;
        s = sf; nzcv_in = nz; lo_code = lc; hi_code = hc;
        vld = 1'b1;
        while (!m_rdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!m_rdy) check("issue_rdy_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        if (push) sb.push_back(model(o, a, b, al, ah, sf, nz, lc, hc));
    endtask

    task automatic wait_result(input string tag, input int rv, input int hold);
        int   cycles = 0;
        bit   got = 0;
        exp_t e;
        while (!got && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (m_vld) got = 1;
        end
        if (!got) begin
            check({tag, "_vld_timeout"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        check({tag, "_latency"}, cycles, XLEN / rv + 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lo"},      m_lo,      e.lo);
        check({tag, "_hi"},      m_hi,      e.hi);
        check({tag, "_lo_en"},   m_lo_en,   e.lo_en);
        check({tag, "_hi_en"},   m_hi_en,   e.hi_en);
        check({tag, "_lo_code"}, m_lo_code, e.lo_code);
        check({tag, "_hi_code"}, m_hi_code, e.hi_code);
        check({tag, "_nzcv_en"}, m_nzcv_en, e.nzcv_en);
        check({tag, "_nzcv"},    m_nzcv,    e.nzcv);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_vld"}, m_vld, 1);
            check({tag, "_hold_lo"},  m_lo,  e.lo);
            check({tag, "_hold_hi"},  m_hi,  e.hi);
            check({tag, "_hold_rdy"}, m_rdy, 0);
        end
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        check({tag, "_post_vld"}, m_vld, 0);
        check({tag, "_post_rdy"}, m_rdy, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},     m_rdy,     1);
        check({tag, "_vld"},     m_vld,     0);
        check({tag, "_lo"},      m_lo,      0);
        check({tag, "_hi"},      m_hi,      0);
        check({tag, "_enables"}, {m_lo_en, m_hi_en, m_nzcv_en}, 0);
        check({tag, "_codes"},   {m_lo_code, m_hi_code}, 0);
        check({tag, "_nzcv"},    m_nzcv,    0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_vld) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[6];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100;
        ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;

        sel = 1; rst = 1'b1; vld = 1'b0; flush = 1'b0; rdy = 1'b0;
        op = '0; op1 = '0; op2 = '0; acc_lo = '0; acc_hi = '0;
        s = 1'b0; nzcv_in = '0; lo_code = '0; hi_code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        issue(1, 3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 1'b1, 4'b0011, 4'd1, 4'd2, 1);
        wait_result("mul", 2, 0);

        issue(1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 4'b0000, 4'd2, 4'd3, 1);
        wait_result("umull", 2, 0);
        issue(1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'b0000, 4'd5, 4'd5, 1);
        wait_result("umull_same", 2, 0);

        issue(1, 3'b111, 32'hFFFF_FFFE, 32'd3, 32'd10, 32'd0, 1'b1, 4'b0010, 4'd4, 4'd6, 1);
        wait_result("smlal", 2, 0);
        issue(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 4'b0001, 4'd7, 4'd8, 1);
        wait_result("smull", 2, 0);
        issue(1, 3'b110, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 4'b0000, 4'd1, 4'd9, 1);
        wait_result("smull_min", 2, 0);

        issue(1, 3'b001, 32'd0, 32'd5, 32'd0, 32'd0, 1'b1, 4'b0000, 4'd3, 4'd0, 1);
        wait_result("mla_zero", 2, 5);

        // Flush during the eighth BUSY cycle.
        issue(1, 3'b000, 32'd11, 32'd13, 32'd0, 32'd0, 1'b1, 4'b0000, 4'd1, 4'd2, 0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_vld", m_vld, 0);
        check("flush_rdy", m_rdy, 1);
        expect_quiet("flush_quiet", 25);
        issue(1, 3'b000, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 4'b0000, 4'd1, 4'd2, 1);
        wait_result("after_flush", 2, 0);

        // A flush in IDLE blocks acceptance.
        @(negedge clk);
        vld = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0; flush = 1'b0;
        check("idle_flush_rdy", m_rdy, 1);
        expect_quiet("idle_flush_quiet", 25);

        // Reset while in FIN.
        issue(1, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 32'd1, 32'd2, 1'b1, 4'b0011, 4'd4, 4'd5, 0);
        repeat (XLEN / 2) @(posedge clk);
        @(negedge clk);
        check("fin_vld_low", m_vld, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_fin");
        rst = 1'b0;
        expect_quiet("rst_fin_quiet", 25);

        for (int inst = 0; inst < 3; inst++) begin
            for (int k = 0; k < 4; k++) begin
                issue(inst, ops[$urandom_range(0, 5)], $urandom, $urandom, $urandom, $urandom,
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
                wait_result($sformatf("rand_r%0d_%0d", (inst == 0) ? 1 : (inst == 1) ? 2 : 4, k),
                            (inst == 0) ? 1 : (inst == 1) ? 2 : 4, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
